// File: rtl/imm_gen_pipe_if.sv
// Decode-to-register-read handshake bundle: instruction in, final immediate out.
// The producer/consumer side uses master; imm_gen_pipe uses slave.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
);
  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_instr;
  logic [TAG_W-1:0]  i_tag;
  logic              o_valid;
  logic              i_ready;
  logic [XLEN-1:0]   o_imm;
  logic [2:0]        o_fmt;
  logic [TAG_W-1:0]  o_tag;
  logic              o_illegal;

  modport slave (
    input  i_valid, i_instr, i_tag, i_ready,
    output o_ready, o_valid, o_imm, o_fmt, o_tag, o_illegal
  );

  modport master (
    output i_valid, i_instr, i_tag, i_ready,
    input  o_ready, o_valid, o_imm, o_fmt, o_tag, o_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Opcode-driven immediate generator for XLEN 32/64 with a 2-entry output FIFO.
// The FIFO holds decoded entries so decode can stall without dropping instructions.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0]       ins;
  logic [6:0]        opc;
  logic [2:0]        f3;
  logic              is_shift;
  logic [XLEN-1:0]   imm_p0;
  logic [2:0]        fmt_p0;
  logic              ill_p0;

  assign ins      = bus.i_instr;
  assign opc      = ins[6:0];
  assign f3       = ins[14:12];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  // Stage p0: combinational decode of the incoming instruction
  always_comb begin
    imm_p0 = '0;
    fmt_p0 = FMT_R;
    ill_p0 = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        fmt_p0 = FMT_U;
        imm_p0 = sext32({ins[31:12], 12'b0});
      end
      OPC_JAL: begin
        fmt_p0 = FMT_J;
        imm_p0 = sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      end
      OPC_JALR, OPC_LOAD, OPC_MISC_MEM: begin
        fmt_p0 = FMT_I;
        imm_p0 = sext32({{20{ins[31]}}, ins[31:20]});
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          fmt_p0 = FMT_SHAMT;
          if (XLEN == 64) begin
            imm_p0 = zext6(ins[25:20]);
          end else begin
            imm_p0 = zext6({1'b0, ins[24:20]});
            ill_p0 = ins[25];
          end
        end else begin
          fmt_p0 = FMT_I;
          imm_p0 = sext32({{20{ins[31]}}, ins[31:20]});
        end
      end
      OPC_OP_IMM32: begin
        if (is_shift) begin
          fmt_p0 = FMT_SHAMT;
          imm_p0 = zext6({1'b0, ins[24:20]});
          ill_p0 = ins[25];
        end else begin
          fmt_p0 = FMT_I;
          imm_p0 = sext32({{20{ins[31]}}, ins[31:20]});
        end
        // The W-form opcodes do not exist on a 32-bit machine
        if (XLEN == 32) ill_p0 = 1'b1;
      end
      OPC_STORE: begin
        fmt_p0 = FMT_S;
        imm_p0 = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
      end
      OPC_BRANCH: begin
        fmt_p0 = FMT_B;
        imm_p0 = sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      end
      OPC_OP: begin
        fmt_p0 = FMT_R;
      end
      OPC_OP32: begin
        fmt_p0 = FMT_R;
        ill_p0 = (XLEN == 32);
      end
      OPC_SYSTEM: begin
        fmt_p0 = FMT_ZIMM;
        imm_p0 = zext6({1'b0, ins[19:15]});
      end
      default: begin
        ill_p0 = 1'b1;
      end
    endcase
  end

  logic [XLEN-1:0]  imm_p1 [2];
  logic [2:0]       fmt_p1 [2];
  logic [TAG_W-1:0] tag_p1 [2];
  logic             ill_p1 [2];
  logic [1:0]       cnt_p1;
  logic [1:0]       cnt_nxt;
  logic             wr_ptr_p1;
  logic             rd_ptr_p1;
  logic             rdy_p1;
  logic             vld_p1;
  logic             push;
  logic             pop;

  // Reset masks the handshake outputs so nothing is exchanged during a reset cycle
  assign vld_p1      = (cnt_p1 != 2'd0) && !i_rst;
  assign bus.o_ready = rdy_p1 && !i_rst;
  assign bus.o_valid = vld_p1;
  assign push        = bus.i_valid && bus.o_ready;
  assign pop         = vld_p1 && bus.i_ready;

  always_comb begin
    cnt_nxt = cnt_p1;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt_p1 + 2'd1;
      2'b01:   cnt_nxt = cnt_p1 - 2'd1;
      default: cnt_nxt = cnt_p1;
    endcase
  end

  // Stage p1: FIFO control state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_p1    <= 2'd0;
      wr_ptr_p1 <= 1'b0;
      rd_ptr_p1 <= 1'b0;
      rdy_p1    <= 1'b1;
    end else begin
      cnt_p1 <= cnt_nxt;
      rdy_p1 <= (cnt_nxt != 2'd2);
      if (push) wr_ptr_p1 <= ~wr_ptr_p1;
      if (pop)  rd_ptr_p1 <= ~rd_ptr_p1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      imm_p1[wr_ptr_p1] <= imm_p0;
      fmt_p1[wr_ptr_p1] <= fmt_p0;
      tag_p1[wr_ptr_p1] <= bus.i_tag;
      ill_p1[wr_ptr_p1] <= ill_p0;
    end
  end

  assign bus.o_imm     = vld_p1 ? imm_p1[rd_ptr_p1] : '0;
  assign bus.o_fmt     = vld_p1 ? fmt_p1[rd_ptr_p1] : 3'd0;
  assign bus.o_tag     = vld_p1 ? tag_p1[rd_ptr_p1] : '0;
  assign bus.o_illegal = vld_p1 ? ill_p1[rd_ptr_p1] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share one stimulus stream.
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) if64 ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) if32 ();

  assign if32.i_valid = if64.i_valid;
  assign if32.i_instr = if64.i_instr;
  assign if32.i_tag   = if64.i_tag;
  assign if32.i_ready = if64.i_ready;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u64 (.i_clk(clk), .i_rst(rst), .bus(if64.slave));
  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u32 (.i_clk(clk), .i_rst(rst), .bus(if32.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if64.i_valid = 1'b0;
    if64.i_instr = 32'h0;
    if64.i_tag   = 8'h0;
    if64.i_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    total++;
    if ({if64.o_valid, if64.o_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_hs got valid/ready=%b%b want 00", if64.o_valid, if64.o_ready);
    end
    total++;
    if ({if64.o_imm, if64.o_fmt, if64.o_tag, if64.o_illegal} !== 76'h0) begin
      bad++;
      $display("FAIL reset_data got imm=%h fmt=%0d tag=%h ill=%b want all zero",
               if64.o_imm, if64.o_fmt, if64.o_tag, if64.o_illegal);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({if64.o_valid, if64.o_ready} !== 2'b01) begin
      bad++;
      $display("FAIL post_reset got valid/ready=%b%b want 01", if64.o_valid, if64.o_ready);
    end
  endtask

  task automatic test_addi();
    if64.i_ready = 1'b1;
    if64.i_valid = 1'b1;
    if64.i_instr = 32'hFFF00093;
    if64.i_tag   = 8'h11;
    tick();
    if64.i_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({if64.o_valid, if64.o_fmt, if64.o_illegal, if64.o_tag} !== {1'b1, 3'd1, 1'b0, 8'h11} ||
        if64.o_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++;
      $display("FAIL addi got v=%b imm=%h fmt=%0d ill=%b tag=%h want 1 ffffffffffffffff 1 0 11",
               if64.o_valid, if64.o_imm, if64.o_fmt, if64.o_illegal, if64.o_tag);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    if64.i_ready = 1'b1;
    if64.i_valid = 1'b1;
    if64.i_instr = 32'h123450B7;
    tick();
    if64.i_instr = 32'h800000B7;
    @(negedge clk);
    total++;
    if (if64.o_valid !== 1'b1 || if64.o_imm !== 64'h0000_0000_1234_5000 || if64.o_fmt !== 3'd4) begin
      bad++;
      $display("FAIL lui1 got v=%b imm=%h fmt=%0d want 1 0000000012345000 4",
               if64.o_valid, if64.o_imm, if64.o_fmt);
    end
    tick();
    if64.i_valid = 1'b0;
    @(negedge clk);
    total++;
    if (if64.o_valid !== 1'b1 || if64.o_imm !== 64'hFFFF_FFFF_8000_0000 || if64.o_fmt !== 3'd4) begin
      bad++;
      $display("FAIL lui2 got v=%b imm=%h fmt=%0d want 1 ffffffff80000000 4",
               if64.o_valid, if64.o_imm, if64.o_fmt);
    end
    total++;
    if (if32.o_imm !== 32'h8000_0000) begin
      bad++;
      $display("FAIL lui2_x32 got imm=%h want 80000000", if32.o_imm);
    end
    tick();
    @(negedge clk);
    total++;
    if (if64.o_valid !== 1'b0 || if64.o_imm !== 64'h0) begin
      bad++;
      $display("FAIL drained got v=%b imm=%h want 0 0", if64.o_valid, if64.o_imm);
    end
  endtask

  task automatic test_branch_shamt();
    if64.i_ready = 1'b1;
    if64.i_valid = 1'b1;
    if64.i_instr = 32'hFE000EE3;
    tick();
    if64.i_instr = 32'h03F09093;
    @(negedge clk);
    total++;
    if (if64.o_imm !== 64'hFFFF_FFFF_FFFF_FFFC || if64.o_fmt !== 3'd3 || if64.o_illegal !== 1'b0) begin
      bad++;
      $display("FAIL beq got imm=%h fmt=%0d ill=%b want fffffffffffffffc 3 0",
               if64.o_imm, if64.o_fmt, if64.o_illegal);
    end
    tick();
    if64.i_valid = 1'b0;
    @(negedge clk);
    total++;
    if (if64.o_imm !== 64'd63 || if64.o_fmt !== 3'd6 || if64.o_illegal !== 1'b0) begin
      bad++;
      $display("FAIL slli64 got imm=%h fmt=%0d ill=%b want 3f 6 0",
               if64.o_imm, if64.o_fmt, if64.o_illegal);
    end
    total++;
    if (if32.o_illegal !== 1'b1 || if32.o_fmt !== 3'd6 || if32.o_imm !== 32'd31) begin
      bad++;
      $display("FAIL slli32 got imm=%h fmt=%0d ill=%b want 1f 6 1",
               if32.o_imm, if32.o_fmt, if32.o_illegal);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [63:0] imm_seen;
    if64.i_ready = 1'b0;
    if64.i_valid = 1'b1;
    if64.i_instr = 32'h00100093;
    if64.i_tag   = 8'd1;
    tick();
    if64.i_instr = 32'h00200093;
    if64.i_tag   = 8'd2;
    tick();
    if64.i_instr = 32'h00300093;
    if64.i_tag   = 8'd3;
    @(negedge clk);
    total++;
    if (if64.o_ready !== 1'b0 || if64.o_tag !== 8'd1 || if64.o_valid !== 1'b1) begin
      bad++;
      $display("FAIL full got ready=%b tag=%0d v=%b want 0 1 1", if64.o_ready, if64.o_tag, if64.o_valid);
    end
    imm_seen = if64.o_imm;
    tick();
    @(negedge clk);
    total++;
    if (if64.o_imm !== imm_seen || if64.o_imm !== 64'd1 || if64.o_tag !== 8'd1) begin
      bad++;
      $display("FAIL stall_hold got imm=%h tag=%0d want 1 1", if64.o_imm, if64.o_tag);
    end
    #1;
    if64.i_ready = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (if64.o_tag !== 8'd2 || if64.o_imm !== 64'd2 || if64.o_ready !== 1'b1) begin
      bad++;
      $display("FAIL drain2 got tag=%0d imm=%h ready=%b want 2 2 1", if64.o_tag, if64.o_imm, if64.o_ready);
    end
    tick();
    if64.i_valid = 1'b0;
    @(negedge clk);
    total++;
    if (if64.o_tag !== 8'd3 || if64.o_imm !== 64'd3 || if64.o_valid !== 1'b1) begin
      bad++;
      $display("FAIL drain3 got tag=%0d imm=%h v=%b want 3 3 1", if64.o_tag, if64.o_imm, if64.o_valid);
    end
    tick();
    @(negedge clk);
    total++;
    if (if64.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty got v=%b want 0", if64.o_valid);
    end
  endtask

  task automatic test_mid_reset();
    if64.i_ready = 1'b0;
    if64.i_valid = 1'b1;
    if64.i_instr = 32'h00400093;
    if64.i_tag   = 8'd4;
    tick();
    if64.i_tag   = 8'd5;
    tick();
    if64.i_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({if64.o_valid, if64.o_ready} !== 2'b00) begin
      bad++;
      $display("FAIL in_reset got valid/ready=%b%b want 00", if64.o_valid, if64.o_ready);
    end
    tick();
    rst = 1'b0;
    if64.i_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({if64.o_valid, if64.o_ready, if64.o_tag} !== {2'b01, 8'd0}) begin
      bad++;
      $display("FAIL after_reset got v=%b ready=%b tag=%0d want 0 1 0",
               if64.o_valid, if64.o_ready, if64.o_tag);
    end
    tick();
    @(negedge clk);
    total++;
    if (if64.o_valid !== 1'b0) begin
      bad++;
      $display("FAIL stale got v=%b tag=%0d want v=0", if64.o_valid, if64.o_tag);
    end
  endtask

  task automatic test_illegal();
    if64.i_ready = 1'b1;
    if64.i_valid = 1'b1;
    if64.i_instr = 32'h0000007F;
    if64.i_tag   = 8'h7F;
    tick();
    if64.i_instr = 32'h0010809B;
    if64.i_tag   = 8'h9B;
    @(negedge clk);
    total++;
    if ({if64.o_valid, if64.o_illegal, if64.o_fmt} !== {2'b11, 3'd0} || if64.o_imm !== 64'h0 ||
        if64.o_tag !== 8'h7F) begin
      bad++;
      $display("FAIL bad_opc got v=%b ill=%b fmt=%0d imm=%h tag=%h want 1 1 0 0 7f",
               if64.o_valid, if64.o_illegal, if64.o_fmt, if64.o_imm, if64.o_tag);
    end
    tick();
    if64.i_valid = 1'b0;
    @(negedge clk);
    total++;
    if (if32.o_illegal !== 1'b1 || if32.o_tag !== 8'h9B) begin
      bad++;
      $display("FAIL addiw32 got ill=%b tag=%h want 1 9b", if32.o_illegal, if32.o_tag);
    end
    total++;
    if (if64.o_illegal !== 1'b0 || if64.o_fmt !== 3'd1 || if64.o_imm !== 64'd1) begin
      bad++;
      $display("FAIL addiw64 got ill=%b fmt=%0d imm=%h want 0 1 1",
               if64.o_illegal, if64.o_fmt, if64.o_imm);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch_shamt();
    test_backpressure();
    test_mid_reset();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Next-generation immediate generator for the decode stage.
- Decodes the format from the opcode itself, so no external format select is needed. Produces architecturally final, sign-/zero-extended immediates for XLEN = 32 or 64, including U-type shifted by 12 and B/J with bit 0 cleared.
- Flags illegal encodings.
- Outputs are buffered behind a 2-entry valid/ready FIFO so decode can stall without losing instructions.
- Sits between fetch/decode and the register-read stage.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
TAG_W, 8, width of the sideband tag carried alongside each instruction (e.g. PC index/ROB id).

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  input instruction valid
o_ready  out  1  block can accept an instruction this cycle
i_instr  in  32  instruction word
i_tag  in  TAG_W  sideband tag
o_valid  out  1  output entry valid
i_ready  in  1  consumer accepts output this cycle
o_imm  out  XLEN  immediate value
o_fmt  out  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
o_tag  out  TAG_W  tag of the output entry
o_illegal  out  1  opcode/shamt not legal for XLEN

Behaviour:
- One clock i_clk; i_rst synchronous, active-high.
- Reset state:
  - count=0, both pointers 0.
  - o_valid=0, o_imm=0, o_fmt=0, o_tag=0, o_illegal=0.
  - o_ready=0 while i_rst=1, then 1 from the first cycle after reset deasserts.
- Decode by opcode i_instr[6:0] (combinational, written into the FIFO on push):
  - LUI 0110111 / AUIPC 0010111: U; {instr[31:12],12'b0}, sign-extended to XLEN.
  - JAL 1101111: J; sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - JALR 1100111, LOAD 0000011, MISC-MEM 0001111: I; sext(instr[31:20]).
  - OP-IMM 0010011:
    - funct3 001 or 101: SHAMT. XLEN=64: zext(instr[25:20]). XLEN=32: zext(instr[24:20]), with illegal=1 if instr[25]=1.
    - Otherwise: I.
  - OP-IMM-32 0011011:
    - funct3 001/101: SHAMT, zext(instr[24:20]); illegal=1 if instr[25]=1.
    - Otherwise: I.
    - Whole opcode illegal when XLEN=32.
  - STORE 0100011: S; sext({instr[31:25],instr[11:7]}).
  - BRANCH 1100011: B; sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - OP 0110011 / OP-32 0111011: R; imm=0. OP-32 is illegal when XLEN=32.
  - SYSTEM 1110011: ZIMM; zext(instr[19:15]).
  - Any other opcode: fmt=R, imm=0, illegal=1.
- Handshake and FIFO (2 entries, each holding imm, fmt, tag, illegal):
  - push = i_valid & o_ready; pop = o_valid & i_ready.
  - o_ready = (count<2), registered; no combinational path from i_ready to o_ready.
  - o_valid = (count>0). Outputs are driven from the head entry and are zero when empty.
  - Latency: an instruction pushed at edge N appears at the outputs after edge N (o_valid=1 in cycle N+1).
  - Throughput: 1 per cycle while i_ready=1.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers are 1 bit and wrap 1→0.
  - While o_valid=1 and i_ready=0, all outputs hold stable.
  - i_valid while o_ready=0: ignored. The producer must hold.
  - Illegal entries are passed through in order, not dropped.
- Reset mid-operation: all entries discarded; o_valid=0 in the cycle after the reset edge.

Test Plan:
1. XLEN=64, i_instr=0xFFF00093 (addi x1,x0,-1), i_ready=1 → one cycle later o_valid=1, o_imm=0xFFFF_FFFF_FFFF_FFFF, o_fmt=1, o_illegal=0.
2. XLEN=64, 0x123450B7 then 0x800000B7 (lui) → o_imm=0x0000_0000_1234_5000, then 0xFFFF_FFFF_8000_0000; o_fmt=4 on consecutive cycles.
3. XLEN=64, 0xFE000EE3 (beq x0,x0,-4) → o_imm=0xFFFF_FFFF_FFFF_FFFC, o_fmt=3. 0x03F09093 (slli x1,x1,63) → o_imm=63, o_fmt=6. Same slli with XLEN=32 → o_illegal=1.
4. Backpressure, i_ready=0: push tags 1, 2, 3 back-to-back → o_ready=0 after 2 pushes; tag 3 held by the producer. Raise i_ready → tags 1, 2, 3 emerge in order, one per cycle; o_imm stable while stalled.
5. Fill 2 entries, assert i_rst for 1 cycle → o_valid=0 and o_ready=0 during reset; o_ready=1 after; stale entries never appear.
6. i_instr=0x0000007F → o_illegal=1, o_imm=0, o_fmt=0. XLEN=32 with 0x0010809B (addiw) → o_illegal=1.
